// File: rtl/lsp_expand_1_pipe.sv
// Lsp_expand_1 stage: enforces minimum spacing GAP between buf[0..4] held in a 2048x32 scratch RAM.
// Optional sticky saturation flag (output ovf) when LSP_EXPAND1_OVF_EN is defined.
module lsp_expand_1_pipe #(
  parameter logic [10:0]        BUF_BASE = 11'h0A0,
  parameter logic signed [15:0] GAP      = 16'sd10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        expand1MuxSel,
  input  logic [10:0] testReadAddr,
  input  logic [10:0] testWriteAddr,
  input  logic [31:0] testMemOut,
  input  logic        testMemWriteEn,
  output logic [31:0] memIn,
  output logic        done
`ifdef LSP_EXPAND1_OVF_EN
  ,
  output logic        ovf
`endif
);

  typedef enum logic [2:0] {IDLE, RD_A, RD_B, CALC, WR_A, WR_B, NEXT, DONE} state_e;

  state_e             state_q, state_d;
  logic [2:0]         j_q, j_d;
  logic               done_q, done_d;
  logic [15:0]        a_q, a_d, na_q, na_d, nb_q, nb_d;
  logic               wr_q, wr_d;

  logic [31:0]        mem [0:2047];
  logic [31:0]        rdata_q;
  logic [10:0]        fsm_raddr, fsm_waddr, raddr, waddr;
  logic [31:0]        fsm_wdata, wdata;
  logic               fsm_we, we;

  function automatic logic [10:0] ea(input logic [2:0] idx);
    return {BUF_BASE[10:4], 1'b0, idx};
  endfunction

  // 17-bit results of 16-bit add/sub; saturate when the top two bits disagree
  function automatic logic [15:0] sat16(input logic [16:0] v);
    if (v[16] != v[15]) return v[16] ? 16'h8000 : 16'h7FFF;
    return v[15:0];
  endfunction

  logic [15:0] b, diff, sum, tmp, na, nb;
  logic [16:0] diff_w, sum_w, na_w, nb_w;
  logic        pos;

  always_comb begin
    b      = rdata_q[15:0];
    diff_w = {a_q[15], a_q} - {b[15], b};
    diff   = sat16(diff_w);
    sum_w  = {diff[15], diff} + {GAP[15], GAP};
    sum    = sat16(sum_w);
    tmp    = {sum[15], sum[15:1]};
    pos    = !tmp[15] && (tmp != 16'h0000);
    na_w   = {a_q[15], a_q} - {tmp[15], tmp};
    nb_w   = {b[15], b} + {tmp[15], tmp};
    na     = sat16(na_w);
    nb     = sat16(nb_w);
  end

`ifdef LSP_EXPAND1_OVF_EN
  logic ovf_q, ovf_d, sat_any;
  always_comb begin
    sat_any = (diff_w[16] != diff_w[15]) || (sum_w[16] != sum_w[15]) ||
              (pos && ((na_w[16] != na_w[15]) || (nb_w[16] != nb_w[15])));
  end
  assign ovf = ovf_q;
`endif

  always_comb begin
    state_d   = state_q;
    j_d       = j_q;
    done_d    = done_q;
    a_d       = a_q;
    na_d      = na_q;
    nb_d      = nb_q;
    wr_d      = wr_q;
    fsm_raddr = ea(j_q - 3'd1);
    fsm_waddr = ea(j_q - 3'd1);
    fsm_wdata = {16'h0000, na_q};
    fsm_we    = 1'b0;
`ifdef LSP_EXPAND1_OVF_EN
    ovf_d     = ovf_q;
`endif
    case (state_q)
      IDLE: if (start) begin
        j_d     = 3'd1;
        done_d  = 1'b0;
        state_d = RD_A;
`ifdef LSP_EXPAND1_OVF_EN
        ovf_d   = 1'b0;
`endif
      end
      RD_A: state_d = RD_B;
      RD_B: begin
        // read data of buf[j-1] arrives now; buf[j] arrives during CALC
        fsm_raddr = ea(j_q);
        a_d       = rdata_q[15:0];
        state_d   = CALC;
      end
      CALC: begin
        na_d    = na;
        nb_d    = nb;
        wr_d    = pos;
        state_d = WR_A;
`ifdef LSP_EXPAND1_OVF_EN
        ovf_d   = ovf_q | sat_any;
`endif
      end
      WR_A: begin
        fsm_we  = wr_q;
        state_d = WR_B;
      end
      WR_B: begin
        fsm_waddr = ea(j_q);
        fsm_wdata = {16'h0000, nb_q};
        fsm_we    = wr_q;
        state_d   = NEXT;
      end
      NEXT: begin
        if (j_q == 3'd4) state_d = DONE;
        else begin
          j_d     = j_q + 3'd1;
          state_d = RD_A;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      j_q     <= 3'd0;
      done_q  <= 1'b0;
      a_q     <= 16'h0000;
      na_q    <= 16'h0000;
      nb_q    <= 16'h0000;
      wr_q    <= 1'b0;
`ifdef LSP_EXPAND1_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      done_q  <= done_d;
      a_q     <= a_d;
      na_q    <= na_d;
      nb_q    <= nb_d;
      wr_q    <= wr_d;
`ifdef LSP_EXPAND1_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign raddr = expand1MuxSel ? testReadAddr   : fsm_raddr;
  assign waddr = expand1MuxSel ? testWriteAddr  : fsm_waddr;
  assign wdata = expand1MuxSel ? testMemOut     : fsm_wdata;
  assign we    = expand1MuxSel ? testMemWriteEn : fsm_we;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_q <= mem[raddr];
  end

  assign memIn = rdata_q;
  assign done  = done_q;

endmodule

// File: tb/tb_lsp_expand_1_pipe.sv
// Directed + randomized bench for lsp_expand_1_pipe; expected buffers queued at start, checked on readback.
module tb_lsp_expand_1_pipe;

  localparam logic [10:0] BASE = 11'h0A0;

  logic        clk = 1'b0;
  logic        reset, start, expand1MuxSel, testMemWriteEn;
  logic [10:0] testReadAddr, testWriteAddr;
  logic [31:0] testMemOut, memIn;
  logic        done;
`ifdef LSP_EXPAND1_OVF_EN
  logic        ovf;
`endif

  lsp_expand_1_pipe dut (
    .clk(clk), .reset(reset), .start(start), .expand1MuxSel(expand1MuxSel),
    .testReadAddr(testReadAddr), .testWriteAddr(testWriteAddr),
    .testMemOut(testMemOut), .testMemWriteEn(testMemWriteEn),
    .memIn(memIn), .done(done)
`ifdef LSP_EXPAND1_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] ld [10];
  logic [31:0] exp_q [$];
  int          mb [5];
  bit          msat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic int sat16(input int v, output bit s);
    s = 1'b0;
    if (v > 32767)  begin s = 1'b1; return 32767;  end
    if (v < -32768) begin s = 1'b1; return -32768; end
    return v;
  endfunction

  // Reference for the C loop over j=1..4, operating on mb[]
  function automatic void model();
    bit s;
    int d, x, t;
    msat = 1'b0;
    for (int j = 1; j < 5; j++) begin
      d = sat16(mb[j-1] - mb[j], s); msat |= s;
      x = sat16(d + 10, s);          msat |= s;
      t = x >>> 1;
      if (t > 0) begin
        mb[j-1] = sat16(mb[j-1] - t, s); msat |= s;
        mb[j]   = sat16(mb[j] + t, s);   msat |= s;
      end
    end
  endfunction

  task automatic set5(input logic [15:0] v0, v1, v2, v3, v4);
    ld[0] = {16'h0, v0}; ld[1] = {16'h0, v1}; ld[2] = {16'h0, v2};
    ld[3] = {16'h0, v3}; ld[4] = {16'h0, v4};
    for (int i = 5; i < 10; i++) ld[i] = 32'd7;
  endtask

  task automatic load_buf();
    expand1MuxSel = 1'b1;
    for (int i = 0; i < 10; i++) begin
      testWriteAddr = {BASE[10:4], 4'(i)};
      testMemOut = ld[i];
      testMemWriteEn = 1'b1;
      @(posedge clk); #1;
    end
    testMemWriteEn = 1'b0;
  endtask

  task automatic push_exp(input logic [31:0] e0, e1, e2, e3, e4);
    exp_q.push_back(e0); exp_q.push_back(e1); exp_q.push_back(e2);
    exp_q.push_back(e3); exp_q.push_back(e4);
    for (int i = 5; i < 10; i++) exp_q.push_back(ld[i]);
  endtask

  task automatic push_model();
    for (int i = 0; i < 5; i++) mb[i] = int'($signed(ld[i][15:0]));
    model();
    push_exp({16'h0, 16'(mb[0])}, {16'h0, 16'(mb[1])}, {16'h0, 16'(mb[2])},
             {16'h0, 16'(mb[3])}, {16'h0, 16'(mb[4])});
  endtask

  task automatic run_pass(input string tag);
    int n;
    expand1MuxSel = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_done_drop"}, {31'h0, done}, 32'h0);
    n = 1;
    while (done !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_done_within_40"}, {31'h0, done}, 32'h1);
  endtask

  task automatic check_buf(input string tag);
    logic [31:0] e;
    expand1MuxSel = 1'b1;
    for (int i = 0; i < 10; i++) begin
      testReadAddr = {BASE[10:4], 4'(i)};
      @(posedge clk); #1;
      if (exp_q.size() == 0) begin
        check({tag, "_queue_empty"}, memIn, 32'hDEAD_BEEF);
        e = 32'h0;
      end else begin
        e = exp_q.pop_front();
        check($sformatf("%s_buf%0d", tag, i), memIn, e);
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; expand1MuxSel = 1'b1; testMemWriteEn = 1'b0;
    testReadAddr = 11'h0; testWriteAddr = 11'h0; testMemOut = 32'h0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("reset_done", {31'h0, done}, 32'h0);
`ifdef LSP_EXPAND1_OVF_EN
    check("reset_ovf", {31'h0, ovf}, 32'h0);
`endif

    // nominal
    set5(16'd1000, 16'd1004, 16'd2000, 16'd2003, 16'd3000);
    load_buf();
    push_exp(32'h3E5, 32'h3EF, 32'h7CD, 32'h7D6, 32'hBB8);
    run_pass("nominal");
    check_buf("nominal");

    // chained update
    set5(16'd500, 16'd500, 16'd500, 16'd500, 16'd500);
    load_buf();
    push_exp(32'h1EF, 32'h1F2, 32'h1F3, 32'h1F3, 32'h1FD);
    run_pass("chain");
    check_buf("chain");

    // saturation
    set5(16'h7FFF, 16'h8000, 16'h0000, 16'h1000, 16'h2000);
    load_buf();
    push_exp(32'h4000, 32'h0000BFFF, 32'h0, 32'h1000, 32'h2000);
    run_pass("sat");
`ifdef LSP_EXPAND1_OVF_EN
    check("sat_ovf", {31'h0, ovf}, 32'h1);
`endif
    check_buf("sat");

    // already spaced
    set5(16'd0, 16'd1000, 16'd2000, 16'd3000, 16'd4000);
    load_buf();
    push_exp(32'd0, 32'd1000, 32'd2000, 32'd3000, 32'd4000);
    run_pass("spaced");
`ifdef LSP_EXPAND1_OVF_EN
    check("spaced_ovf", {31'h0, ovf}, 32'h0);
`endif
    check_buf("spaced");

    // reset mid-pass; j=1 needs no change so memory content is independent of where the pass stopped
    set5(16'd0, 16'd1000, 16'd1004, 16'd2000, 16'd3000);
    load_buf();
    expand1MuxSel = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_done", {31'h0, done}, 32'h0);
    repeat (35) @(posedge clk);
    #1 check("midrst_stays_idle", {31'h0, done}, 32'h0);
    push_exp(32'd0, 32'd997, 32'd1007, 32'd2000, 32'd3000);
    run_pass("midrst_rerun");
    check_buf("midrst_rerun");

    // back-to-back randomized runs against the reference model
    for (int r = 0; r < 120; r++) begin
      int base;
      base = int'($urandom_range(0, 65535));
      for (int i = 0; i < 5; i++) begin
        if ($urandom_range(0, 3) == 0) ld[i] = {16'h0, 16'($urandom)};
        else ld[i] = {16'h0, 16'(base + int'($urandom_range(0, 24)) - 12)};
      end
      for (int i = 5; i < 10; i++) ld[i] = $urandom;
      load_buf();
      push_model();
      run_pass($sformatf("rand%0d", r));
`ifdef LSP_EXPAND1_OVF_EN
      check($sformatf("rand%0d_ovf", r), {31'h0, ovf}, {31'h0, msat});
`endif
      check_buf($sformatf("rand%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
